// File: rtl/morse_tx.sv
// morse_tx: serial on/off keyer. Accepts an MSB-first on/off pattern with an
// explicit length over a valid/ready handshake, plays one bit per unit period,
// then holds a low inter-symbol gap of GAP_UNITS units.
// Optional build macro MORSE_LOOP_EN adds a loop input that replays the last
// accepted symbol without returning to IDLE.
module morse_tx #(
  parameter int PAT_W       = 14,
  parameter int LEN_W       = 4,
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int CNT_W       = 25,
  parameter int GAP_UNITS   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [PAT_W-1:0] sym_pattern,
  input  logic [LEN_W-1:0] sym_len,
  output logic             led_out,
  output logic             busy,
`ifdef MORSE_LOOP_EN
  input  logic             loop,
`endif
  output logic             done
);

  localparam int GAP_W = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_UNITS > 0) ? GAP_UNITS - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(PAT_W);
  localparam bit               HAS_GAP   = (GAP_UNITS > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nx;
  logic [PAT_W-1:0]   r_shift, w_shift_nx;
  logic [LEN_W-1:0]   r_rem,   w_rem_nx;
  logic [GAP_W-1:0]   r_gap,   w_gap_nx;
  logic               r_led,   w_led_nx;
  logic               r_done,  w_done_nx;
  logic [LEN_W-1:0]   w_eff_len;
  logic               w_tick;
  logic               w_finish;
`ifdef MORSE_LOOP_EN
  logic [PAT_W-1:0]   r_orig,     w_orig_nx;
  logic [LEN_W-1:0]   r_orig_len, w_orig_len_nx;
`endif

  assign w_tick    = enable && (r_cnt == UNIT_LAST);
  assign sym_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign led_out   = r_led;
  assign done      = r_done;

  // State and datapath registers; reset discards any in-flight symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_rem   <= '0;
      r_gap   <= '0;
      r_led   <= 1'b0;
      r_done  <= 1'b0;
`ifdef MORSE_LOOP_EN
      r_orig     <= '0;
      r_orig_len <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_shift <= w_shift_nx;
      r_rem   <= w_rem_nx;
      r_gap   <= w_gap_nx;
      r_led   <= w_led_nx;
      r_done  <= w_done_nx;
`ifdef MORSE_LOOP_EN
      r_orig     <= w_orig_nx;
      r_orig_len <= w_orig_len_nx;
`endif
    end
  end

  // Next-state, unit counter, shift/length bookkeeping and registered outputs.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_rem_nx   = r_rem;
    w_gap_nx   = r_gap;
    w_led_nx   = r_led;
    w_done_nx  = 1'b0;
    w_finish   = 1'b0;
    w_eff_len  = (sym_len > LEN_MAX) ? LEN_MAX : sym_len;
`ifdef MORSE_LOOP_EN
    w_orig_nx     = r_orig;
    w_orig_len_nx = r_orig_len;
`endif

    unique case (r_state)
      IDLE: begin
        w_led_nx = 1'b0;
        if (sym_valid) begin
          w_shift_nx = sym_pattern;
          w_rem_nx   = w_eff_len;
          w_cnt_nx   = '0;
          w_gap_nx   = '0;
`ifdef MORSE_LOOP_EN
          w_orig_nx     = sym_pattern;
          w_orig_len_nx = w_eff_len;
`endif
          if (w_eff_len != '0) begin
            w_state_nx = SEND;
            w_led_nx   = sym_pattern[PAT_W-1];
          end else if (HAS_GAP) begin
            w_state_nx = GAP;
          end else begin
            w_done_nx = 1'b1;
          end
        end
      end
      SEND: begin
        if (enable) w_cnt_nx = w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick) begin
          w_shift_nx = {r_shift[PAT_W-2:0], 1'b0};
          w_rem_nx   = r_rem - 1'b1;
          if (r_rem == LEN_W'(1)) begin
            w_led_nx = 1'b0;
            if (HAS_GAP) begin
              w_state_nx = GAP;
              w_gap_nx   = '0;
            end else begin
              w_finish = 1'b1;
            end
          end else begin
            w_led_nx = r_shift[PAT_W-2];
          end
        end
      end
      GAP: begin
        w_led_nx = 1'b0;
        if (enable) w_cnt_nx = w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick) begin
          if (r_gap == GAP_LAST) w_finish = 1'b1;
          else                   w_gap_nx = r_gap + 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_led_nx   = 1'b0;
      end
    endcase

    // Completion of a symbol: pulse done, then either idle or replay.
    if (w_finish) begin
      w_done_nx  = 1'b1;
      w_state_nx = IDLE;
      w_led_nx   = 1'b0;
`ifdef MORSE_LOOP_EN
      if (loop) begin
        w_shift_nx = r_orig;
        w_rem_nx   = r_orig_len;
        w_gap_nx   = '0;
        w_cnt_nx   = '0;
        if (r_orig_len != '0) begin
          w_state_nx = SEND;
          w_led_nx   = r_orig[PAT_W-1];
        end else if (HAS_GAP) begin
          w_state_nx = GAP;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_morse_tx.sv
// tb_morse_tx: self-checking bench for morse_tx. Expected waveforms are built
// as per-cycle bit queues from the pattern/length/gap rules and walked with a
// pointer that only advances on enabled cycles.
module tb_morse_tx;

  localparam int PAT_W = 14;
  localparam int LEN_W = 4;
  localparam int U     = 4;
  localparam int G     = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             sym_valid;
  logic             sym_ready;
  logic [PAT_W-1:0] sym_pattern;
  logic [LEN_W-1:0] sym_len;
  logic             led_out;
  logic             busy;
  logic             done;
`ifdef MORSE_LOOP_EN
  logic             loop;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  morse_tx #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W),
    .UNIT_CYCLES(U),
    .CNT_W(3),
    .GAP_UNITS(G)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .sym_pattern(sym_pattern),
    .sym_len(sym_len),
    .led_out(led_out),
    .busy(busy),
`ifdef MORSE_LOOP_EN
    .loop(loop),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle. Accepts the symbol on the next
  // edge and checks every cycle until the first idle cycle (done pulse).
  task automatic play(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                      input bit hold, input int pause_at, input int pause_len,
                      input bit rnd_en);
    bit q[$];
    int eff, t_len, j, c, budget;
    bit en;
    eff = (int'(len) > PAT_W) ? PAT_W : int'(len);
    for (int i = 0; i < eff; i++)
      for (int u = 0; u < U; u++) q.push_back(pat[PAT_W-1-i]);
    for (int k = 0; k < G * U; k++) q.push_back(1'b0);
    t_len  = q.size();
    budget = t_len * 8 + 40;

    check_eq("ready_before", sym_ready, 1);
    sym_pattern = pat;
    sym_len     = len;
    sym_valid   = 1'b1;
    enable      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) sym_valid = 1'b0;
    j = 0;
    c = 0;
    while (j < t_len && c < budget) begin
      check_eq("led", led_out, q[j]);
      check_eq("busy", busy, 1);
      check_eq("ready_busy", sym_ready, 0);
      check_eq("done_early", done, 0);
      if (pause_at >= 0 && c >= pause_at && c < pause_at + pause_len) en = 1'b0;
      else if (rnd_en) en = ($urandom_range(0, 3) != 0);
      else en = 1'b1;
      enable = en;
      if (en) j++;
      c++;
      @(negedge clk);
    end
    check_eq("finished_in_budget", j, t_len);
    check_eq("done_pulse", done, 1);
    check_eq("ready_after", sym_ready, 1);
    check_eq("busy_after", busy, 0);
    check_eq("led_idle", led_out, 0);
    enable = 1'b1;
  endtask

  initial begin
    logic [PAT_W-1:0] p;
    logic [LEN_W-1:0] l;
    bit h;
    int lead;

    reset       = 1'b1;
    enable      = 1'b1;
    sym_valid   = 1'b0;
    sym_pattern = '0;
    sym_len     = '0;
`ifdef MORSE_LOOP_EN
    loop        = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_led", led_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", sym_ready, 1);

    // Short pattern, full-width pattern, clamped length, zero length.
    play(14'b10101000000000, 4'd5, 1'b0, -1, 0, 1'b0);
    play(14'b11101110111011, 4'd14, 1'b0, -1, 0, 1'b0);
    play(14'b11101110111011, 4'd15, 1'b0, -1, 0, 1'b0);
    play(14'b11111111111111, 4'd0, 1'b0, -1, 0, 1'b0);

    // Back-to-back with sym_valid held: next accept on first idle cycle.
    play(14'b11011000000000, 4'd4, 1'b1, -1, 0, 1'b0);
    play(14'b01100000000001, 4'd14, 1'b1, -1, 0, 1'b0);
    sym_valid = 1'b0;

    // Enable dropped for 10 cycles in the middle of the second unit.
    play(14'b10101000000000, 4'd5, 1'b0, 5, 10, 1'b0);

    // Randomized symbols, lengths, hand-off style and enable pattern.
    for (int n = 0; n < 20; n++) begin
      p = PAT_W'($urandom);
      l = LEN_W'($urandom_range(0, 15));
      h = bit'($urandom_range(0, 1));
      play(p, l, h, -1, 0, 1'b1);
    end
    sym_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of SEND discards the symbol.
    lead = int'($urandom_range(2, 7));
    sym_pattern = 14'b11110000000000;
    sym_len     = 4'd4;
    sym_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sym_valid = 1'b0;
    repeat (lead) @(negedge clk);
    check_eq("midsend_led", led_out, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_led", led_out, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_ready", sym_ready, 1);
    check_eq("midrst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("postrst_ready", sym_ready, 1);
    check_eq("postrst_led", led_out, 0);
    play(14'b10000000000000, 4'd1, 1'b0, -1, 0, 1'b0);

`ifdef MORSE_LOOP_EN
    // Looping: 3 on-units + 3 gap-units = 24-cycle period; loop cleared
    // mid-period so the DUT idles after that period's gap.
    loop        = 1'b1;
    sym_pattern = 14'b11100000000000;
    sym_len     = 4'd3;
    sym_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sym_valid = 1'b0;
    for (int c = 0; c < 96; c++) begin
      check_eq("loop_led", led_out, ((c % 24) < 12) ? 1 : 0);
      check_eq("loop_done", done, (c > 0 && (c % 24) == 0) ? 1 : 0);
      check_eq("loop_busy", busy, 1);
      check_eq("loop_ready", sym_ready, 0);
      if (c == 77) loop = 1'b0;
      @(negedge clk);
    end
    check_eq("loop_end_done", done, 1);
    check_eq("loop_end_ready", sym_ready, 1);
    check_eq("loop_end_led", led_out, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
Name: morse_tx

Overview:
- Parametrised serial on/off keyer that replaces a fixed 8-letter, single-rate Morse LED driver.
- Accepts an arbitrary MSB-aligned on/off pattern with an explicit length through a valid/ready handshake.
- Plays the pattern one bit per unit period, then holds a programmable low inter-symbol gap.
- Sits between a symbol source (LUT or text sequencer) and a board LED or buzzer output.

Parameters:
- PAT_W, 14: pattern register width in units. Bit PAT_W-1 is sent first.
- LEN_W, 4: width of sym_len. Must satisfy 2^LEN_W > PAT_W.
- UNIT_CYCLES, 25_000_000: enabled clock cycles per unit (0.5 s at 50 MHz). Must be >= 1.
- CNT_W, 25: unit counter width. Must satisfy 2^CNT_W >= UNIT_CYCLES.
- GAP_UNITS, 3: low units appended after every pattern. 0 is legal and means no gap.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: run/pause. When low, the unit counter, state and led_out freeze.
- sym_valid, input, 1: sym_pattern and sym_len are valid.
- sym_ready, output, 1: block can accept a symbol. Combinational: high exactly when state is IDLE.
- sym_pattern, input, PAT_W: on/off pattern, MSB first, 1 = on.
- sym_len, input, LEN_W: number of pattern bits to send.
- led_out, output, 1: keyed output. Registered.
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: one-cycle pulse when a symbol including its gap completes.
- loop, input, 1: present only with MORSE_LOOP_EN.

Behaviour:
- Reset (synchronous, priority over everything, including mid-symbol):
  - state = IDLE, led_out = 0, done = 0, unit counter = 0, shift register = 0, remaining count = 0.
  - An in-flight symbol is discarded. sym_ready is high in the cycle after reset deasserts.
- States: IDLE, SEND, GAP.
- IDLE:
  - led_out = 0.
  - On a clock edge with sym_valid && sym_ready (independent of enable): latch sym_pattern into the shift register and latch the effective length, where eff_len = min(sym_len, PAT_W). Clear the unit counter.
  - Next state is SEND if eff_len > 0. Otherwise GAP if GAP_UNITS > 0. Otherwise stay in IDLE and pulse done.
  - led_out = sym_pattern[PAT_W-1] from the cycle after acceptance when entering SEND, else 0.
- Unit tick:
  - The counter increments on enabled cycles.
  - tick = enable && (counter == UNIT_CYCLES-1). On tick, counter returns to 0.
- SEND:
  - On tick: shift the register left by 1 (zero fill) and decrement remaining.
  - If remaining was 1, go to GAP (or IDLE if GAP_UNITS == 0) with led_out = 0. Otherwise led_out = new MSB.
  - Each pattern bit is therefore visible on led_out for exactly UNIT_CYCLES enabled cycles.
- GAP:
  - led_out = 0. Counts GAP_UNITS ticks, then goes to IDLE.
- done:
  - Registered. High for exactly one cycle: the first IDLE cycle after completion, or the cycle after acceptance in the zero-length / zero-gap case.
- Latency: with enable held high, the total from acceptance edge to sym_ready high is (eff_len + GAP_UNITS) * UNIT_CYCLES cycles.
- sym_valid while busy is ignored. Inputs are not sampled outside IDLE.
- Deasserting enable mid-unit stretches that unit. Counter resumes from the frozen value and does not restart.

Optional Feature:
MORSE_LOOP_EN
- Defined:
  - Port loop exists.
  - At the end of GAP (or at the last SEND tick when GAP_UNITS == 0), if loop == 1: reload the latched original pattern and eff_len and return to SEND without passing through IDLE. done still pulses once per repetition. sym_ready stays low.
  - loop == 0 behaves as the undefined case.
  - A separate copy of the original pattern is retained for reload.
- Undefined: no loop port and no pattern copy. Every symbol is one-shot.

Test Plan:
- Bench parameters: PAT_W=14, UNIT_CYCLES=4, GAP_UNITS=3, enable=1.
- Scenario 1: send 14'b10101000000000, len 5 -> led_out holds 1,0,1,0,1 for 4 cycles each, then 12 cycles low. sym_ready is low for 32 cycles. done pulses once.
- Scenario 2: send 14'b11101110111011, len 14 -> 56 cycles of the pattern, 12-cycle gap. Then send len 15 -> clamped to 14, identical waveform.
- Scenario 3: send len 0 -> led_out stays 0. busy for 12 cycles. done pulses.
- Scenario 4: with sym_valid held high and back-to-back symbols -> the second is accepted exactly on the first IDLE cycle. No gap shorter than 12 cycles.
- Scenario 5: drop enable for 10 cycles in the middle of the second unit -> that unit lasts 14 cycles. Assert reset mid-SEND -> next cycle led_out=0, busy=0, sym_ready=1.
- Scenario 6 (MORSE_LOOP_EN): loop=1 with 14'b11100000000000, len 3 -> repeating period of 24 cycles, done pulse every 24 cycles. Clearing loop -> IDLE after the current gap.
